wb_bus_watchdog: RTL and testbench

- Wishbone (pipelined) guard stage that sits directly downstream of the priority arbiter's client port and in front of the peripheral interconnect.
- Passes requests through with zero latency and counts outstanding transactions.
- If the slave stops responding, aborts the bus cycle and returns a single err to the arbiter, so an owner is never deadlocked.
- Provides a saturating timeout-event count for software status.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_wdt_timer.sv | 39 +++
 rtl/wb_bus_watchdog.sv | 133 +++++++++++++
 tb/tb_wb_bus_watchdog.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and width helpers for the Wishbone bus watchdog.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef struct packed {
    logic [WB_AW-1:0]   addr;
    logic [WB_DW-1:0]   data;
    logic [WB_DW/8-1:0] sel;
    logic               we;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } wdt_state_t;

  function automatic int cnt_w(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  function automatic int tmr_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/wb_wdt_timer.sv
// Silence timer: clears on demand, counts while enabled, flags the last cycle before timeout.
module wb_wdt_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = tmr_w(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TW'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_bus_watchdog.sv
// Zero-latency pipelined Wishbone guard: tracks outstanding requests and aborts
// the cycle with a single err upstream when the slave goes silent.
module wb_bus_watchdog
  import wb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int TIMEOUT         = 1023,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          s_cyc,
  input  logic          s_stb,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_data,
  input  logic [DW/8-1:0] s_sel,
  output logic          s_stall,
  output logic          s_ack,
  output logic          s_err,
  output logic [DW-1:0] s_rdata,
  output logic          m_cyc,
  output logic          m_stb,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic [DW/8-1:0] m_sel,
  input  logic          m_stall,
  input  logic          m_ack,
  input  logic          m_err,
  input  logic [DW-1:0] m_rdata,
  output logic [15:0]   timeout_count,
  output logic          timeout_pulse
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);

  wdt_state_t    state_q, state_d;
  logic [CW-1:0] outst_q, outst_d;
  logic          err_q, err_d;
  logic          pulse_q, pulse_d;
  logic [15:0]   tcnt_q, tcnt_d;

  logic in_abort, full, accept, resp, abort_fire;
  logic tmr_clr, tmr_en, tmr_expired;

  wb_wdt_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign in_abort   = (state_q == ABORT);
  assign full       = (outst_q == CW'(MAX_OUTSTANDING));
  assign accept     = m_stb && !m_stall;
  assign resp       = m_cyc && (m_ack || m_err);
  // A response on the expiry edge rescues the transaction.
  assign abort_fire = (state_q == BUSY) && tmr_expired && !resp;

  // Bus outputs are forced quiet while in reset so nothing leaks downstream.
  always_comb begin
    m_cyc         = nRST && s_cyc && !in_abort;
    m_stb         = m_cyc && s_stb && !full;
    m_we          = s_we;
    m_addr        = s_addr;
    m_data        = s_data;
    m_sel         = s_sel;
    s_stall       = m_stall || full || in_abort;
    s_ack         = m_cyc && m_ack;
    s_err         = (m_cyc && m_err) || err_q;
    s_rdata       = m_rdata;
    timeout_count = tcnt_q;
    timeout_pulse = pulse_q;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ABORT) begin
      if (!s_cyc) state_d = IDLE;
    end else if (abort_fire) begin
      state_d = ABORT;
    end else begin
      state_d = (outst_d != '0) ? BUSY : IDLE;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (!m_cyc || m_err || abort_fire) begin
      outst_d = '0;
    end else if (accept && !m_ack) begin
      outst_d = outst_q + CW'(1);
    end else if (!accept && m_ack && outst_q != '0) begin
      outst_d = outst_q - CW'(1);
    end

    err_d   = abort_fire;
    pulse_d = abort_fire;
    tcnt_d  = tcnt_q;
    if (abort_fire && tcnt_q != 16'hFFFF) begin
      tcnt_d = tcnt_q + 16'd1;
    end

    tmr_clr = resp || (accept && state_q == IDLE) || outst_q == '0 || abort_fire;
    tmr_en  = (state_q == BUSY);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      outst_q <= '0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Scoreboard bench for wb_bus_watchdog: directed scenarios plus random traffic
// checked against an integer-level model of the watchdog rules.
module tb_wb_bus_watchdog;
  import wb_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam int MAX_OUT = 3;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [3:0]    s_sel;
  logic          s_stall, s_ack, s_err;
  logic [DW-1:0] s_rdata;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [3:0]    m_sel;
  logic          m_stall, m_ack, m_err;
  logic [DW-1:0] m_rdata;
  logic [15:0]   timeout_count;
  logic          timeout_pulse;

  wb_bus_watchdog #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_data(s_data), .s_sel(s_sel),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_data(m_data), .m_sel(m_sel),
    .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .timeout_count(timeout_count), .timeout_pulse(timeout_pulse)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit            m_cyc, m_stb, s_stall, s_ack, s_err, pulse;
    logic [15:0]   tcnt;
    wb_req_t       req;
    logic [DW-1:0] rdata;
  } status_t;

  typedef struct {
    bit            is_ack, is_err;
    logic [DW-1:0] rdata;
  } resp_t;

  status_t status_q[$];
  resp_t   resp_q[$];

  // Reference model state, kept as plain integers
  int md_outst, md_silent, md_tcount;
  bit md_abort, md_err, md_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    md_outst  = 0;
    md_silent = 0;
    md_tcount = 0;
    md_abort  = 1'b0;
    md_err    = 1'b0;
    md_pulse  = 1'b0;
  endfunction

  function automatic void model_push();
    status_t e;
    bit cyc_ok;
    bit full;
    cyc_ok    = s_cyc && !md_abort;
    full      = (md_outst == MAX_OUT);
    e.m_cyc   = cyc_ok;
    e.m_stb   = cyc_ok && s_stb && !full;
    e.s_stall = m_stall || full || md_abort;
    e.s_ack   = cyc_ok && m_ack;
    e.s_err   = (cyc_ok && m_err) || md_err;
    e.pulse   = md_pulse;
    e.tcnt    = 16'(md_tcount);
    e.req     = '{addr: s_addr, data: s_data, sel: s_sel, we: s_we};
    e.rdata   = m_rdata;
    status_q.push_back(e);
    if (e.s_ack || e.s_err) resp_q.push_back('{is_ack: e.s_ack, is_err: e.s_err, rdata: m_rdata});
  endfunction

  function automatic void model_update();
    bit cyc_ok, full, stall, accept, resp, idle, fire;
    int n;
    cyc_ok = s_cyc && !md_abort;
    full   = (md_outst == MAX_OUT);
    stall  = m_stall || full || md_abort;
    accept = s_cyc && s_stb && !stall;
    resp   = cyc_ok && (m_ack || m_err);
    idle   = (md_outst == 0) && !md_abort;
    fire   = !md_abort && md_outst > 0 && md_silent == TIMEOUT - 1 && !resp;

    if (resp || (accept && idle) || md_outst == 0 || fire) md_silent = 0;
    else if (md_outst > 0 && !md_abort) md_silent++;

    if (!cyc_ok || m_err || fire) begin
      md_outst = 0;
    end else begin
      n = md_outst + int'(accept) - int'(m_ack);
      md_outst = (n < 0) ? 0 : n;
    end

    if (fire) md_abort = 1'b1;
    else if (md_abort && !s_cyc) md_abort = 1'b0;

    md_err   = fire;
    md_pulse = fire;
    if (fire && md_tcount < 65535) md_tcount++;
  endfunction

  // Drive one cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit cyc, input bit stb, input bit stall, input bit ack, input bit err);
    wb_req_t req;
    req     = '{addr: $urandom, data: $urandom, sel: 4'($urandom), we: 1'($urandom)};
    s_cyc   = cyc;
    s_stb   = stb;
    s_we    = req.we;
    s_addr  = req.addr;
    s_data  = req.data;
    s_sel   = req.sel;
    m_stall = stall;
    m_ack   = ack;
    m_err   = err;
    m_rdata = $urandom;
    model_push();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  // Assert reset in the middle of a cycle with a live bus, then release it.
  task automatic reset_mid();
    s_cyc = 1'b1; s_stb = 1'b1; m_ack = 1'b1; m_err = 1'b1; m_stall = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("rst_m_cyc", 32'(m_cyc), 32'(0));
    check("rst_m_stb", 32'(m_stb), 32'(0));
    check("rst_s_ack", 32'(s_ack), 32'(0));
    check("rst_s_err", 32'(s_err), 32'(0));
    check("rst_tcount", 32'(timeout_count), 32'(0));
    check("rst_pulse", 32'(timeout_pulse), 32'(0));
    @(posedge CLK);
    #1 nRST = 1'b1;
    model_reset();
  endtask

  status_t ms;
  resp_t   mr;

  always @(negedge CLK) begin
    if (status_q.size() != 0) begin
      ms = status_q.pop_front();
      check("m_cyc",   32'(m_cyc),         32'(ms.m_cyc));
      check("m_stb",   32'(m_stb),         32'(ms.m_stb));
      check("s_stall", 32'(s_stall),       32'(ms.s_stall));
      check("s_ack",   32'(s_ack),         32'(ms.s_ack));
      check("s_err",   32'(s_err),         32'(ms.s_err));
      check("pulse",   32'(timeout_pulse), 32'(ms.pulse));
      check("tcount",  32'(timeout_count), 32'(ms.tcnt));
      check("m_addr",  m_addr,             ms.req.addr);
      check("m_data",  m_data,             ms.req.data);
      check("m_sel",   32'(m_sel),         32'(ms.req.sel));
      check("m_we",    32'(m_we),          32'(ms.req.we));
      check("s_rdata", s_rdata,            ms.rdata);
    end
    if (s_ack || s_err) begin
      if (resp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL resp_unexpected: got ack=%0b err=%0b expected no response at %0t", s_ack, s_err, $time);
      end else begin
        mr = resp_q.pop_front();
        check("resp_ack", 32'(s_ack), 32'(mr.is_ack));
        check("resp_err", 32'(s_err), 32'(mr.is_err));
        if (mr.is_ack) check("resp_rdata", s_rdata, mr.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got no end of stimulus expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = '0; s_data = '0; s_sel = '0;
    m_stall = 1'b0; m_ack = 1'b1; m_err = 1'b1; m_rdata = '0;
    model_reset();
    #3;
    check("init_m_cyc", 32'(m_cyc), 32'(0));
    check("init_m_stb", 32'(m_stb), 32'(0));
    check("init_s_ack", 32'(s_ack), 32'(0));
    check("init_s_err", 32'(s_err), 32'(0));
    check("init_tcount", 32'(timeout_count), 32'(0));
    check("init_pulse", 32'(timeout_pulse), 32'(0));
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Single read answered three edges later
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // Burst into the outstanding limit, accept+ack together, stray ack at zero
    repeat (5) cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // Ack lands on the expiry edge: no abort
    cycle(1, 1, 0, 0, 0);
    repeat (TIMEOUT - 1) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("race_tcount", 32'(timeout_count), 32'(0));

    // Silent slave: abort, then late ack and stb while aborted, then release
    cycle(1, 1, 0, 0, 0);
    repeat (TIMEOUT + 2) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("timeout_tcount", 32'(timeout_count), 32'(1));

    // Reset with three requests outstanding, then a normal transaction
    repeat (3) cycle(1, 1, 0, 0, 0);
    reset_mid();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cycle($urandom_range(0, 99) >= 8, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            r < 15, r >= 15 && r < 18);
    end
    cycle(0, 0, 0, 0, 0);

    check("resp_queue_drained", 32'(resp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
